// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and default baud divisor.
// Used by both the transmit and receive halves of the board UART path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int DATA_BITS = 8;
  localparam int IDX_BITS  = $clog2(DATA_BITS);

  // 100 MHz system clock at 115200 baud
  localparam int DEFAULT_CLOCKS_PER_BAUD = 868;

  function automatic logic parity_of(
    input logic [DATA_BITS-1:0] d,
    input logic                 odd
  );
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push when full and pop when empty are ignored.
// Read data is the current head entry, valid whenever empty is low.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serialiser.
// Define UART_TX_PARITY_EN to add a parity bit (8-parity-1 frames).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int TIMER_BITS      = 10,
  parameter int CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD,
  parameter int FIFO_AW         = 2,
  parameter int PARITY_ODD      = 0
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 uart_rxd_out,
  output logic                 o_busy,
  output logic [FIFO_AW:0]     o_fifo_count
);

  localparam logic [TIMER_BITS-1:0] RELOAD =
    TIMER_BITS'(CLOCKS_PER_BAUD - 1);
  localparam logic [IDX_BITS-1:0] LAST_BIT =
    IDX_BITS'(DATA_BITS - 1);

  uart_state_t state_q, state_d;

  logic [TIMER_BITS-1:0] timer_q, timer_d;
  logic [IDX_BITS-1:0]   idx_q, idx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  line_q, line_d;
  logic                  busy_q, busy_d;

  logic                  push;
  logic                  pop;
  logic                  load;
  logic                  baud_tick;
  logic [DATA_BITS-1:0]  fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = 1'(PARITY_ODD);
`endif

  // ready depends on occupancy only, so a same-cycle pop never frees a slot
  assign o_ready = !fifo_full;
  assign push    = i_valid && !fifo_full;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .i_reset (i_reset),
    .push    (push),
    .pop     (pop),
    .din     (i_data),
    .dout    (fifo_dout),
    .count   (o_fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign baud_tick = (timer_q == '0);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    line_d  = line_q;
    busy_d  = busy_q;
    pop     = 1'b0;
    load    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    if (state_q != IDLE) begin
      timer_d = baud_tick ? RELOAD : timer_q - 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        line_d = 1'b1;
        busy_d = 1'b0;
        if (!fifo_empty) begin
          load = 1'b1;
        end
      end
      START: begin
        if (baud_tick) begin
          state_d = DATA;
          idx_d   = '0;
          line_d  = shift_q[0];
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            line_d  = par_q;
`else
            state_d = STOP;
            line_d  = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
            line_d  = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          state_d = STOP;
          line_d  = 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_tick) begin
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            line_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        line_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // a pop starts a frame with no idle gap, from IDLE or straight from STOP
    if (load) begin
      pop     = 1'b1;
      state_d = START;
      timer_d = RELOAD;
      shift_d = fifo_dout;
      line_d  = 1'b0;
      busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
      par_d   = parity_of(fifo_dout, 1'(PARITY_ODD));
`endif
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      line_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  assign uart_rxd_out = line_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 4 clocks/baud plus one default-rate instance.
// Honours UART_TX_PARITY_EN for frame length and the parity scenarios.
module tb_uart_tx_fifo;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FL  = FB * CPB;
  localparam int CPB_B = 868;

  typedef struct {
    logic [7:0] d;
    int         rel;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       valid_b = 1'b0;

  logic       ready, line, busy;
  logic [2:0] cnt;
  logic       ready_b, line_b, busy_b;
  logic [2:0] cnt_b;

  int errors = 0;
  int checks = 0;

  ent_t       pend[$];
  logic [7:0] sent[$];
  int         acc_edge [8];
  int         nacc;
  logic       cap_line [400];
  logic       cap_busy [400];
  int         cap_cnt  [400];
  logic       cap_rdy  [400];

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .TIMER_BITS      (10),
    .CLOCKS_PER_BAUD (CPB),
    .FIFO_AW         (2),
    .PARITY_ODD      (0)
  ) dut (
    .clk          (clk),
    .i_reset      (rst),
    .i_data       (data),
    .i_valid      (valid),
    .o_ready      (ready),
    .uart_rxd_out (line),
    .o_busy       (busy),
    .o_fifo_count (cnt)
  );

  uart_tx_fifo dut_b (
    .clk          (clk),
    .i_reset      (rst),
    .i_data       (data),
    .i_valid      (valid_b),
    .o_ready      (ready_b),
    .uart_rxd_out (line_b),
    .o_busy       (busy_b),
    .o_fifo_count (cnt_b)
  );

`ifdef UART_TX_PARITY_EN
  logic       ready_o, line_o, busy_o;
  logic [2:0] cnt_o;
  logic       cap_line_o [400];

  uart_tx_fifo #(
    .TIMER_BITS      (10),
    .CLOCKS_PER_BAUD (CPB),
    .FIFO_AW         (2),
    .PARITY_ODD      (1)
  ) dut_o (
    .clk          (clk),
    .i_reset      (rst),
    .i_data       (data),
    .i_valid      (valid),
    .o_ready      (ready_o),
    .uart_rxd_out (line_o),
    .o_busy       (busy_o),
    .o_fifo_count (cnt_o)
  );
`endif

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected line level for bit slot bi of a frame carrying b
  function automatic logic exp_bit(
    input logic [7:0] b,
    input int         bi,
    input logic       odd
  );
    if (bi == 0) return 1'b0;
    if (bi <= 8) return b[bi-1];
`ifdef UART_TX_PARITY_EN
    if (bi == 9) return (^b) ^ odd;
`else
    if (odd) return 1'b1;
`endif
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sample index c holds outputs just after edge Ec
  task automatic run(input int n);
    logic rdy;
    sent.delete();
    nacc = 0;
    for (int c = 0; c < n; c++) begin
      if (pend.size() > 0 && c >= pend[0].rel) begin
        valid = 1'b1;
        data  = pend[0].d;
      end else begin
        valid = 1'b0;
        data  = 8'hEE;
      end
      rdy = ready;
      tick();
      if (valid && rdy) begin
        acc_edge[nacc] = c;
        nacc++;
        sent.push_back(pend[0].d);
        void'(pend.pop_front());
      end
      cap_line[c] = line;
      cap_busy[c] = busy;
      cap_cnt[c]  = int'(cnt);
      cap_rdy[c]  = ready;
`ifdef UART_TX_PARITY_EN
      cap_line_o[c] = line_o;
`endif
    end
    valid = 1'b0;
  endtask

  // frames start at sample 1 and must run back-to-back
  task automatic check_stream(input string tag, input int nfr);
    int mism;
    int busyn;
    mism  = 0;
    busyn = 0;
    for (int k = 0; k < nfr * FL; k++) begin
      if (cap_line[1+k] !== exp_bit(sent[k/FL], (k % FL) / CPB, 1'b0))
        mism++;
      if (cap_busy[1+k] === 1'b1)
        busyn++;
    end
    chk({tag, "_bits"}, mism, 0);
    chk({tag, "_busy"}, busyn, nfr * FL);
    chk({tag, "_idle"}, {31'd0, cap_line[1+nfr*FL]}, 1);
    chk({tag, "_busyend"}, {31'd0, cap_busy[1+nfr*FL]}, 0);
  endtask

  initial begin
    int lows;
    int busyn;
    int mism;

    #1 rst = 1'b1;
    #2;
    chk("rst_ready", {31'd0, ready}, 1);
    chk("rst_line", {31'd0, line}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_cnt", {29'd0, cnt}, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // single byte
    pend.push_back('{8'h55, 0});
    run(FL + 6);
    chk("single_nacc", nacc, 1);
    chk("single_cnt_e0", cap_cnt[0], 1);
    chk("single_line_e0", {31'd0, cap_line[0]}, 1);
    chk("single_busy_e0", {31'd0, cap_busy[0]}, 0);
    chk("single_fall_e1", {31'd0, cap_line[1]}, 0);
    chk("single_cnt_e1", cap_cnt[1], 0);
    check_stream("single", 1);

    // full FIFO with six bytes held on valid
    for (int i = 1; i <= 6; i++) pend.push_back('{8'(i), 0});
    run(6 * FL + 6);
    chk("full_nacc", nacc, 6);
    chk("full_acc4", acc_edge[4], 4);
    chk("full_cnt4", cap_cnt[4], 4);
    chk("full_rdy4", {31'd0, cap_rdy[4]}, 0);
    chk("full_cnt_pop", cap_cnt[FL+1], 3);
    chk("full_acc5", acc_edge[5], FL + 2);
    check_stream("full", 6);

    // push on the edge where STOP pops, with two queued
    pend.push_back('{8'hA1, 0});
    pend.push_back('{8'h3C, 0});
    pend.push_back('{8'hF0, 0});
    pend.push_back('{8'h0F, FL + 1});
    run(4 * FL + 6);
    chk("sim_nacc", nacc, 4);
    chk("sim_acc3", acc_edge[3], FL + 1);
    chk("sim_cnt_before", cap_cnt[FL], 2);
    chk("sim_cnt_after", cap_cnt[FL+1], 2);
    check_stream("sim", 4);

`ifdef UART_TX_PARITY_EN
    pend.push_back('{8'h07, 0});
    run(FL + 6);
    check_stream("par_even", 1);
    chk("par_even_bit", {31'd0, cap_line[1+9*CPB+1]}, 1);
    chk("par_odd_bit", {31'd0, cap_line_o[1+9*CPB+1]}, 0);
    chk("par_odd_cnt", {29'd0, cnt_o}, 0);
`endif

    // reset during data bit 3 with two bytes queued
    pend.push_back('{8'h00, 0});
    pend.push_back('{8'h11, 0});
    pend.push_back('{8'h22, 0});
    run(1 + 4 * CPB + 2);
    chk("rst_mid_line_before", {31'd0, cap_line[1+4*CPB+1]}, 0);
    chk("rst_mid_cnt_before", cap_cnt[1+4*CPB+1], 2);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_line", {31'd0, line}, 1);
    chk("rst_mid_cnt", {29'd0, cnt}, 0);
    chk("rst_mid_busy", {31'd0, busy}, 0);
    chk("rst_mid_ready", {31'd0, ready}, 1);
    #1 rst = 1'b0;
    run(3 * FL);
    lows  = 0;
    busyn = 0;
    for (int k = 0; k < 3 * FL; k++) begin
      if (cap_line[k] !== 1'b1) lows++;
      if (cap_busy[k] !== 1'b0) busyn++;
    end
    chk("rst_after_quiet", lows, 0);
    chk("rst_after_busy", busyn, 0);

    // default-rate instance: 0xA3 at 868 clocks per bit
    data    = 8'hA3;
    valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    data    = 8'h00;
    chk("baud_cnt_e0", {29'd0, cnt_b}, 1);
    chk("baud_ready_e0", {31'd0, ready_b}, 1);
    mism  = 0;
    busyn = 0;
    for (int k = 0; k < FB * CPB_B; k++) begin
      tick();
      if (line_b !== exp_bit(8'hA3, k / CPB_B, 1'b0)) mism++;
      if (busy_b === 1'b1) busyn++;
    end
    chk("baud_bits", mism, 0);
    chk("baud_busy", busyn, FB * CPB_B);
    tick();
    chk("baud_idle", {31'd0, line_b}, 1);
    chk("baud_busyend", {31'd0, busy_b}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter: accepts bytes over a valid/ready handshake, queues them in a small FIFO and serialises each as 8N1 (optionally 8-parity-1) on the board's UART output line. It is the stand-alone transmit half of the board UART path and sits between on-chip byte producers and the pin toward the host. Bit timing uses a down-counting baud timer, the same scheme as the board UART receive logic.

## Interface
- `TIMER_BITS`, 10: width of the baud timer.
- `CLOCKS_PER_BAUD`, 868: clocks per bit. 100 MHz / 115200 baud. Legal range ≥2.
- `FIFO_AW`, 2: FIFO address width. Depth is 2^FIFO_AW entries.
- `PARITY_ODD`, 0: selects odd parity when 1 and even parity when 0. Used only with `UART_TX_PARITY_EN`.
- `clk`  in  1: single clock. All logic is on its rising edge.
- `i_reset`  in  1: asynchronous, active-high reset.
- `i_data`  in  8: byte to send.
- `i_valid`  in  1: `i_data` is valid.
- `o_ready`  out  1: the FIFO can accept a byte. Reset value 1.
- `uart_rxd_out`  out  1: serial line. Idles high. Reset value 1.
- `o_busy`  out  1: a frame is in progress. Reset value 0.
- `o_fifo_count`  out  FIFO_AW+1: number of bytes queued, excluding the byte currently being shifted. Reset value 0.

## Operation
- **Accept rule:** a byte is accepted on any edge where `i_valid && o_ready`. `o_ready = (o_fifo_count != 2^FIFO_AW)`. `o_ready` is a function of the count only. A pop in the same cycle never makes room for a push in that cycle.
- **States:** IDLE → START → DATA → [PARITY] → STOP → (IDLE | START).
- **IDLE:** line is 1 and `o_busy` is 0. If the FIFO is non-empty: pop the head into the shift register, drive the line 0, load the timer with CLOCKS_PER_BAUD−1, and go to START.
- **START:** line is 0. When the timer reaches 0, go to DATA with bit index 0.
- **DATA:** line = shift[0], LSB first. At each timer 0, shift right. After bit 7 completes, go to PARITY (macro on) or STOP.
- **PARITY:** line = XOR of the 8 data bits, XOR PARITY_ODD.
- **STOP:** line is 1 for one bit time. At timer 0:
  - FIFO non-empty: pop and go straight to START. There is no idle gap between frames.
  - FIFO empty: go to IDLE.
- **Timer:** reloads with CLOCKS_PER_BAUD−1 at every bit boundary and decrements otherwise. Every bit lasts exactly CLOCKS_PER_BAUD clocks.
- **FIFO pointers:** read and write pointers wrap modulo 2^FIFO_AW. The count increments on push only, decrements on pop only, and holds on simultaneous push and pop.
- **Reset:** asserting reset mid-frame immediately forces the line to 1, clears the FIFO and count, and returns the FSM to IDLE. The partial frame is abandoned.
- **`i_data` hold:** `i_data` is sampled only on the accept edge. It may change freely otherwise.

## Timing
- **Latency:** with the FIFO empty and IDLE, accept at edge E0 gives `uart_rxd_out` falling at E1. Count reads 1 for exactly one cycle.
- **`o_busy`:** rises at the same edge as the start-bit fall. Falls at the edge where the line returns to idle after the last stop bit, and stays 1 across back-to-back frames.
- **Frame length:** 10·CLOCKS_PER_BAUD clocks, or 11·CLOCKS_PER_BAUD with parity.
- **Throughput:** one frame per frame length, sustained while the FIFO is non-empty.
- **Outputs:** all outputs are registered. There are no combinational paths from `i_valid` to any output.

## Configuration
- **`UART_TX_PARITY_EN` defined:** the PARITY state is present. Frame is start, 8 data, parity, stop (11 bits).
- **`UART_TX_PARITY_EN` undefined:** the PARITY state and parity logic are absent. Frame is 8N1 (10 bits), and `PARITY_ODD` is ignored.

## Structure
- **Shared package `uart_pkg`:** holds the FSM state enum (IDLE, START, DATA, PARITY, STOP), the data width constant (8) and the default CLOCKS_PER_BAUD. The board UART receive logic shares these.
- **Sub-module `sync_fifo`:** synchronous FIFO, parameterised by width and address width. Ports: push, pop, din, dout, count, full, empty. Async active-high reset.

## Test plan
All scenarios run with CLOCKS_PER_BAUD=4 and FIFO_AW=2.
- **Single byte:** send 0x55 from idle → line falls 1 clock after accept. Line sequence is 0,1,0,1,0,1,0,1,0,1, each level held 4 clocks. `o_busy` is 1 for 40 clocks. Line is 1 afterwards.
- **Full FIFO:** hold `i_valid` with 6 bytes 0x01..0x06 → 5 are accepted (1 into the shifter, 4 queued) and `o_ready` drops. 0x06 is accepted once the second frame starts. Six frames go out back-to-back with no idle clocks, in order.
- **Simultaneous push/pop:** push on the edge where STOP pops the next byte with count 2 → count stays 2 and no byte is lost or duplicated.
- **Parity (`UART_TX_PARITY_EN`):**
  - 0x07 with PARITY_ODD=0 → parity bit 1, frame 44 clocks.
  - 0x07 with PARITY_ODD=1 → parity bit 0.
- **Reset mid-frame:** assert `i_reset` during data bit 3 with 2 bytes queued → line is 1 immediately (asynchronously) and count is 0. After release, no transmission occurs until a new accept.
- **Baud wrap:** default parameters, send 0xA3 → each bit lasts exactly 868 clocks and the frame lasts 8680 clocks.
